pmt_gate_down_counter: RTL and testbench

Programmable down-counter that generates the PMT photon-counting gate window. A preset is loaded, counted down to zero at a prescaled clock rate, and a one-cycle terminal-count pulse is emitted. It is the count-down counterpart of the existing up counter: the up counter accumulates events, and this block defines the window in which they are accumulated. Optional auto-reload produces back-to-back gate windows.

---
 rtl/pmt_timer_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 58 +++++
 rtl/pmt_gate_down_counter.sv | 140 ++++++++++++++
 tb/tb_pmt_gate_down_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_timer_pkg.sv
// ---------------------------------------------------------------------------
// pmt_timer_pkg
// Shared definitions for the PMT photon-counting timer blocks (the up counter's
// control wrapper and the gate down-counter).
//   ST_IDLE / ST_RUN / ST_HOLD : state encodings
//   state_e                    : enum built on those encodings
//   state_is_busy()            : true while a window is active (RUN or HOLD)
// ---------------------------------------------------------------------------
package pmt_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return (s == S_RUN) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the enable stream by PRESCALE: an internal counter walks
// 0..PRESCALE-1 on every enabled cycle and tick is raised on the enabled cycle
// where it sits at PRESCALE-1 (the counter wraps to 0 on that same edge).
// When en is low the counter freezes; clear forces it back to 0.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clear in  return the divider to phase 0 (takes precedence over en)
//   en    in  advance the divider this cycle
//   tick  out combinational; high on the enabled cycle that completes a period
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Every enabled cycle is a tick; no state needed.
            logic unused_in;
            assign unused_in = ^{clk, reset, clear};
            assign tick      = en;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] cnt_q;
            logic [PW-1:0] cnt_d;

            assign tick = en && (cnt_q == LAST);

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pmt_gate_down_counter.sv
// ---------------------------------------------------------------------------
// pmt_gate_down_counter
// Generates the PMT counting gate: a preset is loaded, counted down to zero at
// the prescaled rate, and a one-cycle tc_pulse marks terminal count. With
// auto_reload high at terminal count the preset is reloaded for back-to-back
// windows without a dead cycle.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         capture load_value into preset and count (IDLE only)
//   load_value   preset value
//   start        begin the window (IDLE only, needs a non-zero effective count)
//   stop         abort to IDLE, keeping the remaining count
//   hold         level; freezes count and prescaler phase while high
//   auto_reload  level; sampled at terminal count
//   count        remaining count            (registered)
//   busy         high in RUN or HOLD         (registered)
//   gate         high in RUN only            (registered)
//   tc_pulse     one-cycle terminal pulse    (registered)
// Priority inside a cycle: reset > stop > hold > tick.
// ---------------------------------------------------------------------------
module pmt_gate_down_counter
    import pmt_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             gate,
    output logic             tc_pulse
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] preset_q;
    logic             busy_q;
    logic             gate_q;
    logic             tc_q;

    logic             pre_en;
    logic             pre_clear;
    logic             tick;
    logic [WIDTH-1:0] eff_count;

    // A start in the same cycle as a load judges the value being loaded.
    assign eff_count = load ? load_value : count_q;

    // The divider runs in HOLD too once hold has dropped, so the cycle that
    // leaves HOLD already counts and the window stretches by exactly the
    // number of held cycles.
    assign pre_en    = state_is_busy(state_q) && !stop && !hold;
    assign pre_clear = (state_q == S_IDLE) || stop;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            preset_q <= '0;
            busy_q   <= 1'b0;
            gate_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        preset_q <= load_value;
                        count_q  <= load_value;
                    end
                    if (start && (eff_count != '0)) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        gate_q  <= 1'b1;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (stop) begin
                        // Remaining count is kept; a coincident terminal tick is dropped.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        gate_q  <= 1'b0;
                    end else if (hold) begin
                        state_q <= S_HOLD;
                        gate_q  <= 1'b0;
                    end else begin
                        state_q <= S_RUN;
                        gate_q  <= 1'b1;
                        if (tick) begin
                            // <= 1 rather than == 1 so the count can never wrap.
                            if (count_q <= ONE) begin
                                tc_q <= 1'b1;
                                if (auto_reload) begin
                                    count_q <= preset_q;
                                end else begin
                                    count_q <= '0;
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    gate_q  <= 1'b0;
                                end
                            end else begin
                                count_q <= count_q - ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    gate_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign gate     = gate_q;
    assign tc_pulse = tc_q;

endmodule

// File: tb/tb_pmt_gate_down_counter.sv
// ---------------------------------------------------------------------------
// tb_pmt_gate_down_counter
// Two instances (PRESCALE = 1 and PRESCALE = 4) share one clock. The driver
// applies one directed vector per cycle to the selected instance and queues
// the hand-computed outputs expected after the next rising edge; the monitor
// pops and compares one entry per rising edge.
// ---------------------------------------------------------------------------
module tb_pmt_gate_down_counter;

    localparam int W  = 16;
    localparam int EW = 1 + W + 3;   // {sel, count, busy, gate, tc}

    logic clk;

    logic         p1_reset, p1_load, p1_start, p1_stop, p1_hold, p1_ar;
    logic [W-1:0] p1_lv, p1_count;
    logic         p1_busy, p1_gate, p1_tc;

    logic         p4_reset, p4_load, p4_start, p4_stop, p4_hold, p4_ar;
    logic [W-1:0] p4_lv, p4_count;
    logic         p4_busy, p4_gate, p4_tc;

    logic          sel;              // 0 -> PRESCALE 1 instance, 1 -> PRESCALE 4
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec;
    int            n_miss;

    pmt_gate_down_counter #(.WIDTH(W), .PRESCALE(1)) u_p1 (
        .clk         (clk),
        .reset       (p1_reset),
        .load        (p1_load),
        .load_value  (p1_lv),
        .start       (p1_start),
        .stop        (p1_stop),
        .hold        (p1_hold),
        .auto_reload (p1_ar),
        .count       (p1_count),
        .busy        (p1_busy),
        .gate        (p1_gate),
        .tc_pulse    (p1_tc)
    );

    pmt_gate_down_counter #(.WIDTH(W), .PRESCALE(4)) u_p4 (
        .clk         (clk),
        .reset       (p4_reset),
        .load        (p4_load),
        .load_value  (p4_lv),
        .start       (p4_start),
        .stop        (p4_stop),
        .hold        (p4_hold),
        .auto_reload (p4_ar),
        .count       (p4_count),
        .busy        (p4_busy),
        .gate        (p4_gate),
        .tc_pulse    (p4_tc)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver: args = reset, load, load_value, start, stop, hold, auto_reload,
    //               expected count, busy, gate, tc, name
    task automatic cyc(input logic rs, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp, input logic hd, input logic ar,
                       input logic [W-1:0] ec, input logic eb, input logic eg,
                       input logic et, input string nm);
        @(negedge clk);
        {p1_reset, p1_load, p1_start, p1_stop, p1_hold, p1_ar} = '0;
        {p4_reset, p4_load, p4_start, p4_stop, p4_hold, p4_ar} = '0;
        p1_lv = '0;
        p4_lv = '0;
        if (sel == 1'b0) begin
            p1_reset = rs; p1_load = ld; p1_lv = lv; p1_start = st;
            p1_stop = sp; p1_hold = hd; p1_ar = ar;
        end else begin
            p4_reset = rs; p4_load = ld; p4_lv = lv; p4_start = st;
            p4_stop = sp; p4_hold = hd; p4_ar = ar;
        end
        exp_q.push_back({sel, ec, eb, eg, et});
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        string         nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = e[EW-1] ? {1'b1, p4_count, p4_busy, p4_gate, p4_tc}
                              : {1'b0, p1_count, p1_busy, p1_gate, p1_tc};
                n_vec++;
                if (act !== e) begin
                    n_miss++;
                    $display("FAIL %s: got count=%0d busy=%0b gate=%0b tc=%0b, want count=%0d busy=%0b gate=%0b tc=%0b",
                             nm, act[W+2:3], act[2], act[1], act[0],
                             e[W+2:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_vec  = 0;
        n_miss = 0;
        sel    = 1'b0;
        {p1_load, p1_start, p1_stop, p1_hold, p1_ar} = '0;
        {p4_load, p4_start, p4_stop, p4_hold, p4_ar} = '0;
        p1_lv = '0;
        p4_lv = '0;
        p1_reset = 1'b1;
        p4_reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- PRESCALE = 1 ----------------
        sel = 1'b0;
        cyc(1,0,0,0,0,0,0, 0,0,0,0, "p1_reset");
        // load 5, start: 5,4,3,2,1,0 with one tc
        cyc(0,1,5,0,0,0,0, 5,0,0,0, "t1_load");
        cyc(0,0,0,1,0,0,0, 5,1,1,0, "t1_start");
        cyc(0,0,0,0,0,0,0, 4,1,1,0, "t1_c4");
        cyc(0,0,0,0,0,0,0, 3,1,1,0, "t1_c3");
        cyc(0,0,0,0,0,0,0, 2,1,1,0, "t1_c2");
        cyc(0,0,0,0,0,0,0, 1,1,1,0, "t1_c1");
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "t1_tc");
        cyc(0,0,0,0,0,0,0, 0,0,0,0, "t1_after");
        // start with count 0 is ignored
        cyc(0,0,0,1,0,0,0, 0,0,0,0, "zero_start");
        // load 4 + start together runs 4; load during RUN ignored
        cyc(0,1,4,1,0,0,0, 4,1,1,0, "ldst_start");
        cyc(0,1,9,1,0,0,0, 3,1,1,0, "ld_in_run");
        cyc(0,0,0,0,0,0,0, 2,1,1,0, "ldst_c2");
        cyc(0,0,0,0,0,0,0, 1,1,1,0, "ldst_c1");
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "ldst_tc");
        cyc(0,0,0,0,0,0,0, 0,0,0,0, "ldst_after");
        // auto-reload with N = 2, then stop keeps the count
        cyc(0,1,2,0,0,0,1, 2,0,0,0, "ar_load");
        cyc(0,0,0,1,0,0,1, 2,1,1,0, "ar_start");
        for (int i = 0; i < 3; i++) begin
            cyc(0,0,0,0,0,0,1, 1,1,1,0, "ar_c1");
            cyc(0,0,0,0,0,0,1, 2,1,1,1, "ar_reload");
        end
        cyc(0,0,0,0,1,0,0, 2,0,0,0, "ar_stop");
        // auto-reload with N = 1: pulse on every tick
        cyc(0,1,1,0,0,0,1, 1,0,0,0, "ar1_load");
        cyc(0,0,0,1,0,0,1, 1,1,1,0, "ar1_start");
        for (int i = 0; i < 3; i++) begin
            cyc(0,0,0,0,0,0,1, 1,1,1,1, "ar1_tc");
        end
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "ar1_last_tc");
        cyc(0,0,0,0,0,0,0, 0,0,0,0, "ar1_after");
        // stop coincident with terminal tick: no pulse, pre-tick count kept
        cyc(0,1,1,0,0,0,0, 1,0,0,0, "stoptc_load");
        cyc(0,0,0,1,0,0,0, 1,1,1,0, "stoptc_start");
        cyc(0,0,0,0,1,0,0, 1,0,0,0, "stoptc_stop");
        cyc(0,0,0,0,0,0,0, 1,0,0,0, "stoptc_after");
        // hold for 3 cycles after 2 decrements, stop after 1 more
        cyc(0,1,6,0,0,0,0, 6,0,0,0, "hold_load");
        cyc(0,0,0,1,0,0,0, 6,1,1,0, "hold_start");
        cyc(0,0,0,0,0,0,0, 5,1,1,0, "hold_c5");
        cyc(0,0,0,0,0,0,0, 4,1,1,0, "hold_c4");
        for (int i = 0; i < 3; i++) begin
            cyc(0,0,0,0,0,1,0, 4,1,0,0, "hold_frozen");
        end
        cyc(0,0,0,0,0,0,0, 3,1,1,0, "hold_resume");
        cyc(0,0,0,0,1,0,0, 3,0,0,0, "hold_stop");
        cyc(0,0,0,0,0,0,0, 3,0,0,0, "hold_idle");
        // stop while in HOLD (stop beats hold)
        cyc(0,1,3,0,0,0,0, 3,0,0,0, "hstop_load");
        cyc(0,0,0,1,0,0,0, 3,1,1,0, "hstop_start");
        cyc(0,0,0,0,0,1,0, 3,1,0,0, "hstop_hold");
        cyc(0,0,0,0,1,1,0, 3,0,0,0, "hstop_stop");
        // reset mid-RUN at count 7
        cyc(0,1,9,0,0,0,0, 9,0,0,0, "rst_load");
        cyc(0,0,0,1,0,0,0, 9,1,1,0, "rst_start");
        cyc(0,0,0,0,0,0,0, 8,1,1,0, "rst_c8");
        cyc(0,0,0,0,0,0,0, 7,1,1,0, "rst_c7");
        cyc(1,0,0,0,0,0,0, 0,0,0,0, "rst_midrun");
        cyc(0,0,0,1,0,0,0, 0,0,0,0, "rst_start_ign");
        cyc(0,1,2,1,0,0,0, 2,1,1,0, "rst_reload");
        cyc(0,0,0,0,0,0,0, 1,1,1,0, "rst_c1");
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "rst_tc");

        // ---------------- PRESCALE = 4 ----------------
        sel = 1'b1;
        cyc(1,0,0,0,0,0,0, 0,0,0,0, "p4_reset");
        // load 3: decrement every 4th cycle, 12-cycle window
        cyc(0,1,3,0,0,0,0, 3,0,0,0, "p4_load");
        cyc(0,0,0,1,0,0,0, 3,1,1,0, "p4_start");
        for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,0,0, 3,1,1,0, "p4_c3");
        for (int i = 0; i < 4; i++) cyc(0,0,0,0,0,0,0, 2,1,1,0, "p4_c2");
        for (int i = 0; i < 4; i++) cyc(0,0,0,0,0,0,0, 1,1,1,0, "p4_c1");
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "p4_tc");
        cyc(0,0,0,0,0,0,0, 0,0,0,0, "p4_after");
        // hold freezes prescaler phase; stop clears it
        cyc(0,1,2,0,0,0,0, 2,0,0,0, "p4h_load");
        cyc(0,0,0,1,0,0,0, 2,1,1,0, "p4h_start");
        cyc(0,0,0,0,0,0,0, 2,1,1,0, "p4h_ph1");
        cyc(0,0,0,0,0,1,0, 2,1,0,0, "p4h_hold");
        cyc(0,0,0,0,0,1,0, 2,1,0,0, "p4h_hold");
        cyc(0,0,0,0,0,0,0, 2,1,1,0, "p4h_ph2");
        cyc(0,0,0,0,0,0,0, 2,1,1,0, "p4h_ph3");
        cyc(0,0,0,0,0,0,0, 1,1,1,0, "p4h_tick");
        cyc(0,0,0,0,1,0,0, 1,0,0,0, "p4h_stop");
        cyc(0,0,0,1,0,0,0, 1,1,1,0, "p4h_restart");
        for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,0,0, 1,1,1,0, "p4h_phase0");
        cyc(0,0,0,0,0,0,0, 0,0,0,1, "p4h_tc");

        // Drain: the last vector must have been checked by now
        @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
